pio_input_filter: RTL and testbench
===================================

# pio_input_filter

Input conditioning stage that sits directly upstream of the PIO block's `idata` port. Each pin is synchronised into `clk`, debounced by a per-pin glitch filter with a runtime length, and edge-detected. Per-pin sticky edge-event bits OR together into one level interrupt. The `filtered` output connects straight to the PIO `idata` input.

## Interface

Parameters:
- `pioWidth`, 10, number of pins; must match the downstream PIO.
- `filterWidth`, 4, width of the filter length and the per-pin counters (maximum length 2^filterWidth-1).
- `syncStages`, 2, synchroniser depth; minimum 2.

Ports:
- `clk`  input  1  clock.
- `reset_n`  input  1  reset; asynchronous assert, active-low.
- `pin_i`  input  pioWidth  raw asynchronous pad inputs.
- `filter_len`  input  filterWidth  glitch filter length L (quasi-static, may change at any time).
- `rise_en`  input  pioWidth  per-pin enable for rising-edge events.
- `fall_en`  input  pioWidth  per-pin enable for falling-edge events.
- `evt_clr`  input  pioWidth  per-pin one-cycle clear pulse for pending events (write-1-to-clear source).
- `filtered`  output  pioWidth  debounced pin levels; drives PIO `idata`.
- `evt_pending`  output  pioWidth  sticky per-pin edge-event flags.
- `irq`  output  1  OR of `evt_pending`.

## Operation

Reset (asynchronous, `reset_n` low):
- All synchroniser flops, `filtered`, counters and `evt_pending` clear to 0.
- `irq` is therefore 0.
- Reset mid-count abandons the count. A pin held high through reset appears as a rising edge after reset.

Per pin i, all bits independent:
- **Synchroniser.** `pin_i[i]` passes through `syncStages` flops. The last flop is `s[i]`.
- **Filter state** is the stable level `filtered[i]` plus counter `cnt[i]` (filterWidth bits).
  - If `s[i] == filtered[i]`: `cnt[i]` <= 0.
  - Else if `cnt[i] >= filter_len`: `filtered[i]` <= `s[i]` and `cnt[i]` <= 0.
  - Else: `cnt[i]` <= `cnt[i]` + 1.
  - The `>=` compare makes a mid-count reduction of `filter_len` take effect on the next cycle. The counter never wraps.
  - Effect: a level must be seen at `s[i]` for L+1 consecutive cycles before it is accepted. Shorter pulses are rejected, and `cnt` returns to 0 when `s` reverts.
- **Edge detect.** The cycle in which `filtered[i]` updates is the edge.
  - Update to 1 is a rise; update to 0 is a fall.
  - `set[i]` = (rise & `rise_en[i]`) | (fall & `fall_en[i]`).
- **Pending register.**
  - `set[i]` makes `evt_pending[i]` <= 1.
  - Else `evt_clr[i]` makes `evt_pending[i]` <= 0.
  - Else it holds.
  - Simultaneous set and clear: set wins, so no event is lost.
  - Deasserting `rise_en`/`fall_en` does not clear an already pending bit.
- **Interrupt.** `irq` = |`evt_pending`, combinational from registers with no added cycle.

## Timing

- Edge 1 is the first rising edge of `clk` that samples a new stable `pin_i` value.
- `filtered` changes at edge `syncStages` + L + 1.
  - With defaults and L=0: edge 3.
  - With L=15: edge 18.
- `evt_pending` and `irq` change at the same edge as `filtered`.
- Clear latency: `evt_clr` high during cycle n means `evt_pending` is 0 after edge n+1, unless a new set lands on that edge.
- No backpressure and no handshake. Every edge that passes the filter produces exactly one set attempt.
- Pin toggles faster than L+1 cycles never reach `filtered`, so no event and no irq.

## Test plan

- **Reset/idle:** assert `reset_n`=0 with `pin_i`=0x3FF, then release.
  - During reset: `filtered`=0, `evt_pending`=0, `irq`=0.
  - With L=0 and `rise_en`=0x3FF: `filtered`=0x3FF at edge 3 after release, `evt_pending`=0x3FF, `irq`=1.
- **Latency sweep:** with L=0, 1, 15, step `pin_i[0]` 0->1.
  - `filtered[0]` rises at edges 3, 4 and 18 respectively.
  - With `rise_en[0]`=1, `evt_pending[0]` rises on the same edge.
- **Glitch rejection:** L=3, drive `pin_i[5]` high for 3 cycles then low.
  - `filtered[5]` stays 0 and `evt_pending`=0.
  - Repeat with 4 cycles high: `filtered[5]` pulses high, rise flagged only if `rise_en[5]`=1.
- **Edge selection:** `rise_en`=0x001, `fall_en`=0x002, toggle pins 0 and 1 up then down.
  - Final `evt_pending`=0x003: pin 0 set on its rise, pin 1 set only on its fall.
- **Clear vs set collision:** pulse `evt_clr[2]` in the same cycle that `filtered[2]` rises with `rise_en[2]`=1.
  - `evt_pending[2]` stays 1.
  - A later lone `evt_clr`=0x004 clears it, and `irq` drops on the same edge when no other bit is pending.
- **Mid-count length change and async reset:** L=10, hold `pin_i[3]` high; when `cnt`=6, set L=2.
  - `filtered[3]` updates at the next edge.
  - Separately, pulse `reset_n` low mid-count: all outputs return to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pio_input_filter_if.sv
// rtl/pio_input_filter_if.sv - pin, filter config and event signals of the PIO input filter
interface pio_input_filter_if #(
    parameter int pioWidth    = 10,
    parameter int filterWidth = 4
);
    logic [pioWidth-1:0]    pin_i;
    logic [filterWidth-1:0] filter_len;
    logic [pioWidth-1:0]    rise_en;
    logic [pioWidth-1:0]    fall_en;
    logic [pioWidth-1:0]    evt_clr;
    logic [pioWidth-1:0]    filtered;
    logic [pioWidth-1:0]    evt_pending;
    logic                   irq;

    modport master (
        output pin_i, filter_len, rise_en, fall_en, evt_clr,
        input  filtered, evt_pending, irq
    );

    modport slave (
        input  pin_i, filter_len, rise_en, fall_en, evt_clr,
        output filtered, evt_pending, irq
    );
endinterface

// File: rtl/pio_input_filter.sv
// rtl/pio_input_filter.sv - per-pin synchroniser, glitch filter, edge detect and sticky event irq
module pio_input_filter #(
    parameter int pioWidth    = 10,
    parameter int filterWidth = 4,
    parameter int syncStages  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    pio_input_filter_if.slave bus
);

    logic [pioWidth-1:0]    sync_q [syncStages];
    logic [filterWidth-1:0] cnt_q  [pioWidth];
    logic [pioWidth-1:0]    filtered_q;
    logic [pioWidth-1:0]    pending_q;
    logic [pioWidth-1:0]    s;
    logic [pioWidth-1:0]    update;
    logic [pioWidth-1:0]    set;

    assign s = sync_q[syncStages-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < syncStages; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= bus.pin_i;
            for (int k = 1; k < syncStages; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // The >= compare lets a lowered filter_len take effect mid-count and keeps cnt from wrapping.
    always_comb begin
        update = '0;
        set    = '0;
        for (int i = 0; i < pioWidth; i++) begin
            update[i] = (s[i] != filtered_q[i]) && (cnt_q[i] >= bus.filter_len);
            set[i]    = update[i] && (s[i] ? bus.rise_en[i] : bus.fall_en[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filtered_q <= '0;
            for (int i = 0; i < pioWidth; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < pioWidth; i++) begin
                if (s[i] == filtered_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (update[i]) begin
                    filtered_q[i] <= s[i];
                    cnt_q[i]      <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + filterWidth'(1);
                end
            end
        end
    end

    // Set has priority over clear so an edge landing with a clear pulse is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= set | (pending_q & ~bus.evt_clr);
        end
    end

    assign bus.filtered    = filtered_q;
    assign bus.evt_pending = pending_q;
    assign bus.irq         = |pending_q;

endmodule

// File: tb/tb_pio_input_filter.sv
// tb/tb_pio_input_filter.sv - directed table and corner-case sequences for pio_input_filter
module tb_pio_input_filter;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_fail;

    pio_input_filter_if #(.pioWidth(10), .filterWidth(4)) bus ();

    pio_input_filter #(.pioWidth(10), .filterWidth(4), .syncStages(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] pin;
        logic [3:0] len;
        logic [9:0] rise;
        logic [9:0] fall;
        logic [9:0] clr;
        int         wait_cyc;
        logic [9:0] exp_filt;
        logic [9:0] exp_pend;
        logic       exp_irq;
    } vec_t;

    vec_t vecs [11];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        bus.pin_i      = '0;
        bus.filter_len = '0;
        bus.rise_en    = '0;
        bus.fall_en    = '0;
        bus.evt_clr    = '0;
        step(2);
        reset_n = 1'b1;
        step(1);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        //              pin    L  rise   fall   clr   wait filt   pend   irq
        vecs[0]  = '{10'h000, 0, 10'h001, 10'h002, 10'h000, 4, 10'h000, 10'h000, 1'b0};
        vecs[1]  = '{10'h003, 0, 10'h001, 10'h002, 10'h000, 2, 10'h000, 10'h000, 1'b0};
        vecs[2]  = '{10'h003, 0, 10'h001, 10'h002, 10'h000, 1, 10'h003, 10'h001, 1'b1};
        vecs[3]  = '{10'h000, 0, 10'h001, 10'h002, 10'h000, 3, 10'h000, 10'h003, 1'b1};
        vecs[4]  = '{10'h000, 0, 10'h001, 10'h002, 10'h003, 1, 10'h000, 10'h000, 1'b0};
        vecs[5]  = '{10'h3FF, 0, 10'h3FF, 10'h000, 10'h000, 3, 10'h3FF, 10'h3FF, 1'b1};
        vecs[6]  = '{10'h3FF, 0, 10'h3FF, 10'h000, 10'h3F0, 1, 10'h3FF, 10'h00F, 1'b1};
        vecs[7]  = '{10'h3FF, 0, 10'h000, 10'h000, 10'h000, 2, 10'h3FF, 10'h00F, 1'b1};
        vecs[8]  = '{10'h1FF, 0, 10'h000, 10'h200, 10'h00F, 1, 10'h3FF, 10'h000, 1'b0};
        vecs[9]  = '{10'h1FF, 0, 10'h000, 10'h200, 10'h000, 2, 10'h1FF, 10'h200, 1'b1};
        vecs[10] = '{10'h1FF, 0, 10'h000, 10'h200, 10'h200, 1, 10'h1FF, 10'h000, 1'b0};

        // Reset with all pins high, then release: pins appear as rising edges at edge 3.
        reset_n        = 1'b0;
        bus.pin_i      = 10'h3FF;
        bus.filter_len = 4'd0;
        bus.rise_en    = 10'h3FF;
        bus.fall_en    = '0;
        bus.evt_clr    = '0;
        step(3);
        chk("rst_filtered", 32'(bus.filtered), 32'h0);
        chk("rst_pending",  32'(bus.evt_pending), 32'h0);
        chk("rst_irq",      32'(bus.irq), 32'h0);
        reset_n = 1'b1;
        step(2);
        chk("rel_filtered_e2", 32'(bus.filtered), 32'h0);
        step(1);
        chk("rel_filtered_e3", 32'(bus.filtered), 32'h3FF);
        chk("rel_pending_e3",  32'(bus.evt_pending), 32'h3FF);
        chk("rel_irq_e3",      32'(bus.irq), 32'h1);

        // Table of stepped vectors: edge selection, clears, enable removal.
        do_reset();
        for (int v = 0; v < 11; v++) begin
            bus.pin_i      = vecs[v].pin;
            bus.filter_len = vecs[v].len;
            bus.rise_en    = vecs[v].rise;
            bus.fall_en    = vecs[v].fall;
            bus.evt_clr    = vecs[v].clr;
            step(vecs[v].wait_cyc);
            bus.evt_clr = '0;
            chk($sformatf("vec%0d_filtered", v), 32'(bus.filtered), 32'(vecs[v].exp_filt));
            chk($sformatf("vec%0d_pending", v),  32'(bus.evt_pending), 32'(vecs[v].exp_pend));
            chk($sformatf("vec%0d_irq", v),      32'(bus.irq), 32'(vecs[v].exp_irq));
        end

        // Latency sweep on pin 0: edge 3, 4 and 18 for L = 0, 1, 15.
        for (int t = 0; t < 3; t++) begin
            int lat;
            logic [3:0] len;
            len = (t == 0) ? 4'd0 : (t == 1) ? 4'd1 : 4'd15;
            lat = (t == 0) ? 3 : (t == 1) ? 4 : 18;
            do_reset();
            bus.filter_len = len;
            bus.rise_en    = 10'h001;
            bus.pin_i      = 10'h001;
            step(lat - 1);
            chk($sformatf("lat%0d_filt_before", lat), 32'(bus.filtered[0]), 32'h0);
            chk($sformatf("lat%0d_pend_before", lat), 32'(bus.evt_pending[0]), 32'h0);
            step(1);
            chk($sformatf("lat%0d_filt_at", lat), 32'(bus.filtered[0]), 32'h1);
            chk($sformatf("lat%0d_pend_at", lat), 32'(bus.evt_pending[0]), 32'h1);
        end

        // Glitch rejection with L=3: 3 high cycles rejected, 4 accepted.
        do_reset();
        bus.filter_len = 4'd3;
        bus.rise_en    = 10'h020;
        bus.pin_i      = 10'h020;
        step(3);
        bus.pin_i = 10'h000;
        step(10);
        chk("glitch3_filtered", 32'(bus.filtered), 32'h0);
        chk("glitch3_pending",  32'(bus.evt_pending), 32'h0);
        for (int r = 0; r < 2; r++) begin
            do_reset();
            bus.filter_len = 4'd3;
            bus.rise_en    = (r == 0) ? 10'h020 : 10'h000;
            bus.pin_i      = 10'h020;
            step(4);
            bus.pin_i = 10'h000;
            step(1);
            chk($sformatf("pulse4_r%0d_filt_e5", r), 32'(bus.filtered[5]), 32'h0);
            step(1);
            chk($sformatf("pulse4_r%0d_filt_e6", r), 32'(bus.filtered[5]), 32'h1);
            chk($sformatf("pulse4_r%0d_pend", r), 32'(bus.evt_pending), (r == 0) ? 32'h020 : 32'h0);
            step(10);
            chk($sformatf("pulse4_r%0d_filt_end", r), 32'(bus.filtered[5]), 32'h0);
        end

        // Clear colliding with a set on pin 2: set wins; lone clear later drops irq.
        do_reset();
        bus.rise_en = 10'h004;
        bus.pin_i   = 10'h004;
        step(2);
        bus.evt_clr = 10'h004;
        step(1);
        bus.evt_clr = 10'h000;
        chk("collide_filtered", 32'(bus.filtered[2]), 32'h1);
        chk("collide_pending",  32'(bus.evt_pending), 32'h004);
        chk("collide_irq",      32'(bus.irq), 32'h1);
        step(2);
        bus.evt_clr = 10'h004;
        step(1);
        bus.evt_clr = 10'h000;
        chk("lone_clr_pending", 32'(bus.evt_pending), 32'h0);
        chk("lone_clr_irq",     32'(bus.irq), 32'h0);

        // Mid-count shortening of L on pin 3: cnt reaches 6 after edge 8, update at edge 9.
        do_reset();
        bus.filter_len = 4'd10;
        bus.pin_i      = 10'h008;
        step(8);
        bus.filter_len = 4'd2;
        chk("midlen_filt_before", 32'(bus.filtered[3]), 32'h0);
        step(1);
        chk("midlen_filt_after", 32'(bus.filtered[3]), 32'h1);

        // Asynchronous reset mid-count clears outputs without a clock edge.
        do_reset();
        bus.rise_en = 10'h3FF;
        bus.pin_i   = 10'h3FF;
        step(3);
        chk("pre_areset_filtered", 32'(bus.filtered), 32'h3FF);
        bus.filter_len = 4'd15;
        bus.pin_i      = 10'h000;
        step(5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("areset_filtered", 32'(bus.filtered), 32'h0);
        chk("areset_pending",  32'(bus.evt_pending), 32'h0);
        chk("areset_irq",      32'(bus.irq), 32'h0);
        step(1);
        reset_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
